// File: rtl/bayer_col_window.sv
// Vertical 5-tap Bayer column window: four line buffers, window registered 1 clk after each accepted pixel.
// Optional macro TOP_MIRROR_EN mirrors the top border so that centre rows 0 and 1 are also emitted.
module bayer_col_window #(
  parameter int WIDTH = 640,
  parameter int COL_W = 12,
  parameter int ROW_W = 12,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] m2,
  output logic [PIX_W-1:0] m1,
  output logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             frame_active
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;
`ifdef TOP_MIRROR_EN
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(2);
`else
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(4);
`endif

  logic [PIX_W-1:0] lb0_q [WIDTH];
  logic [PIX_W-1:0] lb1_q [WIDTH];
  logic [PIX_W-1:0] lb2_q [WIDTH];
  logic [PIX_W-1:0] lb3_q [WIDTH];

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_active_q, frame_active_d;
  logic [PIX_W-1:0] m2_q, m2_d, m1_q, m1_d, c_q, c_d, p1_q, p1_d, p2_q, p2_d;
  logic             out_valid_q, out_valid_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;

  logic             accept;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] rd0, rd1, rd2, rd3;

  always_comb begin
    accept  = pix_valid && (sof || frame_active_q);
    // sof relabels the pixel it arrives with as (0,0)
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    addr    = cur_col[AW-1:0];
    rd0     = lb0_q[addr];
    rd1     = lb1_q[addr];
    rd2     = lb2_q[addr];
    rd3     = lb3_q[addr];

    col_d          = col_q;
    row_d          = row_q;
    frame_active_d = frame_active_q;
    m2_d           = m2_q;
    m1_d           = m1_q;
    c_d            = c_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    out_valid_d    = 1'b0;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;

    if (accept) begin
      frame_active_d = 1'b1;
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == ROW_MAX) ? cur_row : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      p2_d = pix_in;
      p1_d = rd0;
      c_d  = rd1;
      m1_d = rd2;
      m2_d = rd3;
`ifdef TOP_MIRROR_EN
      // Mirror from rows of the current frame only; older buffers may hold a previous frame
      if (cur_row == ROW_W'(2)) begin
        m2_d = pix_in;
        m1_d = rd0;
      end else if (cur_row == ROW_W'(3)) begin
        m2_d = rd1;
      end
`endif
      out_valid_d = (cur_row >= FIRST_ROW);
      out_row_d   = cur_row - ROW_W'(2);
      out_col_d   = cur_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      frame_active_q <= 1'b0;
      m2_q           <= '0;
      m1_q           <= '0;
      c_q            <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      out_valid_q    <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      frame_active_q <= frame_active_d;
      m2_q           <= m2_d;
      m1_q           <= m1_d;
      c_q            <= c_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      out_valid_q    <= out_valid_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
    end
  end

  // Line shift: each buffer takes the old content of the one above it at this column
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb0_q[addr] <= pix_in;
      lb1_q[addr] <= rd0;
      lb2_q[addr] <= rd1;
      lb3_q[addr] <= rd2;
    end
  end

  assign m2           = m2_q;
  assign m1           = m1_q;
  assign c            = c_q;
  assign p1           = p1_q;
  assign p2           = p2_q;
  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_bayer_col_window.sv
// Bench for bayer_col_window (WIDTH=4): directed plan stimulus plus random pixels/stalls vs a frame-store model.
module tb_bayer_col_window;

  localparam int W = 4;
`ifdef TOP_MIRROR_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 4;
`endif

  logic        clk;
  logic        rst;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        sof;
  logic [11:0] m2, m1, c, p1, p2;
  logic        out_valid;
  logic [11:0] out_row;
  logic [11:0] out_col;
  logic        frame_active;

  bayer_col_window #(.WIDTH(W), .COL_W(12), .ROW_W(12), .PIX_W(12)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .m2(m2), .m1(m1), .c(c), .p1(p1), .p2(p2),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  // Reference model: current frame stored as a picture, window read by row offsets
  logic [11:0] frame [64][W];
  bit          m_active = 0;
  int          m_row = 0;
  int          m_col = 0;
  logic [11:0] e_m2 = 0, e_m1 = 0, e_c = 0, e_p1 = 0, e_p2 = 0;
  logic [11:0] e_row = 0, e_col = 0;
  bit          e_valid = 0;
  bit          d_known = 0;
  bit          rc_known = 0;

  task automatic cyc(input logic v, input logic s, input logic [11:0] p, input logic r);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    rst       = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_active = 0; m_row = 0; m_col = 0;
      e_m2 = 0; e_m1 = 0; e_c = 0; e_p1 = 0; e_p2 = 0;
      e_row = 0; e_col = 0; e_valid = 0;
      d_known = 1; rc_known = 1;
    end else if (v && (s || m_active)) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      m_active = 1;
      e_valid  = (m_row >= FIRST);
      if (e_valid) begin
        e_p2 = p;
        e_p1 = frame[m_row-1][m_col];
        e_c  = frame[m_row-2][m_col];
        if (m_row == 2) begin
          e_m1 = e_p1;
          e_m2 = p;
        end else if (m_row == 3) begin
          e_m1 = frame[0][m_col];
          e_m2 = e_c;
        end else begin
          e_m1 = frame[m_row-3][m_col];
          e_m2 = frame[m_row-4][m_col];
        end
      end
      d_known  = e_valid;
      rc_known = 1;
      e_row    = 12'(m_row - 2);
      e_col    = 12'(m_col);
      if (m_row < 64) frame[m_row][m_col] = p;
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row++;
      end
    end else begin
      e_valid = 0;
    end

    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("frame_active", 32'(frame_active), 32'(m_active));
    if (rc_known) begin
      check("out_row", 32'(out_row), 32'(e_row));
      check("out_col", 32'(out_col), 32'(e_col));
    end
    if (d_known) begin
      check("m2", 32'(m2), 32'(e_m2));
      check("m1", 32'(m1), 32'(e_m1));
      check("c",  32'(c),  32'(e_c));
      check("p1", 32'(p1), 32'(e_p1));
      check("p2", 32'(p2), 32'(e_p2));
    end
  endtask

  initial begin
    pix_valid = 0; sof = 0; pix_in = 0; rst = 1;

    // Reset, then valid pixels without sof must be ignored
    repeat (2) cyc(0, 0, 12'd0, 1);
    check("rst_m2", 32'(m2), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 12'($urandom), 0);
    check("idle_fa", 32'(frame_active), 32'd0);
    check("idle_vld", 32'(out_valid), 32'd0);

    // Frame A: plan pattern pix = 16*row + col
    for (int r = 0; r < 6; r++) begin
      for (int x = 0; x < W; x++) begin
        cyc(1, (r == 0 && x == 0), 12'(16 * r + x), 0);
`ifdef TOP_MIRROR_EN
        if (r == 2 && x == 0) begin
          check("mir_vld", 32'(out_valid), 32'd1);
          check("mir_m2", 32'(m2), 32'd32);
          check("mir_m1", 32'(m1), 32'd16);
          check("mir_c", 32'(c), 32'd0);
          check("mir_row", 32'(out_row), 32'd0);
        end
        if (r == 3 && x == 2) begin
          check("mir3_m2", 32'(m2), 32'd18);
          check("mir3_m1", 32'(m1), 32'd2);
          check("mir3_c", 32'(c), 32'd18);
        end
`else
        if (r == 3 && x == 3) check("top_novld", 32'(out_valid), 32'd0);
        if (r == 4 && x == 0) begin
          check("first_vld", 32'(out_valid), 32'd1);
          check("first_row", 32'(out_row), 32'd2);
        end
`endif
        if (r == 4 && x == 1) begin
          for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 12'hABC, 0);
            check("stall_vld", 32'(out_valid), 32'd0);
            check("stall_c", 32'(c), 32'd33);
          end
        end
        if (r == 4 && x == 2) begin
          check("post_stall_col", 32'(out_col), 32'd2);
          check("post_stall_c", 32'(c), 32'd34);
        end
        if (r == 5 && x == 1) begin
          check("ss_m2", 32'(m2), 32'd17);
          check("ss_m1", 32'(m1), 32'd33);
          check("ss_c", 32'(c), 32'd49);
          check("ss_p1", 32'(p1), 32'd65);
          check("ss_p2", 32'(p2), 32'd81);
          check("ss_row", 32'(out_row), 32'd3);
          check("ss_col", 32'(out_col), 32'd1);
        end
      end
    end

    // Frame B: mid-frame sof at (4,3), then reset at (5,2)
    for (int r = 0; r < 5; r++)
      for (int x = 0; x < W; x++)
        if (!(r == 4 && x == 3)) cyc(1, (r == 0 && x == 0), 12'(100 + 16 * r + x), 0);
    cyc(1, 1, 12'd0, 0);
    check("midsof_vld", 32'(out_valid), 32'd0);
    check("midsof_col", 32'(out_col), 32'd0);
    for (int i = 1; i < 5 * W + 2; i++) cyc(1, 0, 12'(16 * (i / W) + (i % W)), 0);
    cyc(1, 0, 12'd82, 1);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_fa", 32'(frame_active), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 12'($urandom), 0);

    // Random frame with stalls and one mid-frame sof
    cyc(1, 1, 12'($urandom), 0);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 12'($urandom), 0);
      else cyc(1, (i == 50), 12'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bayer_col_window.md
Name: bayer_col_window

Overview:
- Streaming vertical 5-tap window generator for the CFA pipeline.
- Takes raster-order 12-bit Bayer pixels, one per valid cycle.
- Buffers four previous lines and presents a vertical column (m2, m1, c, p1, p2) centred two rows behind the input row.
- Feeds the vertical instance of the green H/V interpolation filter. It is the producer side of that filter's 5-tap input interface.

Parameters:
- WIDTH, 640, active pixels per line; 4 ≤ WIDTH ≤ 2^COL_W.
- COL_W, 12, column counter width.
- ROW_W, 12, row counter width.
- PIX_W, 12, pixel width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pix_in  in  PIX_W  input pixel
- pix_valid  in  1  pix_in valid this cycle; low = stall
- sof  in  1  start of frame, qualified by pix_valid; marks pixel (row 0, col 0)
- m2  out  PIX_W  row centre-2
- m1  out  PIX_W  row centre-1
- c  out  PIX_W  centre row
- p1  out  PIX_W  row centre+1
- p2  out  PIX_W  row centre+2
- out_valid  out  1  window valid, one-cycle pulse per emitted column
- out_row  out  ROW_W  centre row index of the emitted window
- out_col  out  COL_W  column index of the emitted window
- frame_active  out  1  high from the first accepted sof onward

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset state: all outputs 0; col/row counters 0; frame_active 0; line-buffer contents don't-care.
- Idle after reset: pixels with pix_valid=1 but no prior sof are ignored; no state change.
- sof && pix_valid: col=0, row=0, frame_active=1, and the pixel is accepted as (0,0). An sof mid-frame restarts the counters the same way; the old frame is abandoned with no flush.
- Line buffers: four WIDTH×PIX_W RAMs, lb0..lb3, addressed by col.
  - Read-before-write in the accept cycle: lb0←pix_in, lb1←old lb0, lb2←old lb1, lb3←old lb2.
  - Contents: lb0 = row r-1, lb1 = r-2, lb2 = r-3, lb3 = r-4, where r is the current input row.
- Accepted pixel at (r, x), with all outputs registered 1 cycle later:
  - p2 = pix_in, p1 = lb0[x], c = lb1[x], m1 = lb2[x], m2 = lb3[x].
  - out_row = r-2, out_col = x.
  - out_valid = 1 when r ≥ 4 (or r ≥ 2 with the optional feature).
- Counters:
  - col wraps WIDTH-1→0, and row then increments.
  - row saturates at 2^ROW_W-1; the emitted window content is unaffected by saturation.
- Stall: pix_valid=0 → no counter or RAM change; out_valid=0 next cycle; data outputs hold their last values.
- Bottom border: centre rows H-2 and H-1 are never emitted (no flush). The downstream block handles them.
- Latency: exactly 1 clk from the accepted pixel to out_valid. Throughput is 1 window per clock.
- rst mid-frame overrides everything. The first pixels after rst require a new sof.

Optional Feature:
- Macro: TOP_MIRROR_EN.
- Defined: top-border rows are mirrored so that centre rows 0 and 1 are emitted. Mirroring uses live data only, so no stale RAM data is used after a mid-frame sof.
  - At r=2: m2=p2 (row 2) and m1=p1 (row 1).
  - At r=3: m2=c (row 1); m1 is normal.
  - out_valid is asserted for r ≥ 2.
- Undefined: no mirror logic; out_valid only for r ≥ 4, so the first emitted centre row is 2.

Test Plan (WIDTH=4, pix_in = 16·row + col):
- Reset/idle: hold rst 2 cycles, then drive pix_valid=1 with no sof for 8 cycles → all outputs 0, out_valid 0, frame_active 0.
- Steady state: sof at (0,0), stream 6 rows; at accepted pixel (5,1)=81 → next cycle m2=17, m1=33, c=49, p1=65, p2=81, out_row=3, out_col=1, out_valid=1.
- Top border, TOP_MIRROR_EN defined: pixel (2,0)=32 → m2=32, m1=16, c=0, p1=16, p2=32, out_row=0. Then pixel (3,2)=50 → m2=18, m1=2, c=18, p1=34, p2=50.
- Top border, TOP_MIRROR_EN undefined: no out_valid through end of row 3; first out_valid at pixel (4,0)=64 with out_row=2.
- Stall: drop pix_valid for 3 cycles after pixel (4,1) → out_valid 0 and outputs held during the stall. Pixel (4,2)=66 then emits out_col=2 with c=34.
- Mid-frame sof and reset: sof at pixel (4,3) → treated as (0,0), out_valid stays low until r reaches threshold again. rst at (5,2) → outputs 0, and later pixels are ignored until the next sof.
